miriscv_imem_responder: RTL and testbench

MIRISCV_IMEM_RESPONDER -- requirements
Module: miriscv_imem_responder

---
 rtl/miriscv_imem_responder.sv | 99 +++++++++
 tb/tb_miriscv_imem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_imem_responder.sv
// Instruction-memory responder: word-addressed program memory with a program-load
// write port and a fixed-latency, in-order fetch response pipeline.
module miriscv_imem_responder #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 1
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            instr_req_i,
  input  logic [XLEN-1:0] instr_addr_i,
  output logic            instr_rvalid_o,
  output logic [XLEN-1:0] instr_rdata_o,
  output logic            instr_err_o,
  input  logic            load_we_i,
  input  logic [XLEN-1:0] load_addr_i,
  input  logic [XLEN-1:0] load_wdata_i,
  output logic [2:0]      pending_cnt_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = LATENCY * XLEN;
  // One bit wider than the address so the byte-size bound itself is representable.
  localparam logic [XLEN:0] MEM_BYTES = (XLEN+1)'(MEM_WORDS) << 2;

  // Program memory; deliberately not reset so contents survive a pipeline reset.
  logic [XLEN-1:0] mem_q [MEM_WORDS];

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  logic            req_err;
  logic [XLEN-1:0] req_rdata;
  logic            stage0_err;
  logic [XLEN-1:0] stage0_data;

  // Response pipeline: stage 0 is filled by the request, stage LATENCY-1 drives outputs.
  logic [LATENCY-1:0]           vld_q, vld_d;
  logic [LATENCY-1:0]           err_q, err_d;
  logic [LATENCY-1:0][XLEN-1:0] data_q, data_d;
  logic [2:0]                   cnt_q, cnt_d;

  // Decode the fetch address and read the array in the request cycle.
  always_comb begin
    req_err     = (instr_addr_i[1:0] != 2'b00) || ({1'b0, instr_addr_i} >= MEM_BYTES);
    req_rdata   = mem_q[instr_addr_i[AW+1:2]];
    stage0_err  = instr_req_i & req_err;
    stage0_data = (instr_req_i && !req_err) ? req_rdata : '0;
  end

  // Qualify program-load writes: aligned, in range, and never while reset is held.
  always_comb begin
    mem_we    = arstn_i && load_we_i && (load_addr_i[1:0] == 2'b00)
                && ({1'b0, load_addr_i} < MEM_BYTES);
    mem_waddr = load_addr_i[AW+1:2];
    mem_wdata = load_wdata_i;
  end

  // Array write; a same-edge read has already sampled the old word into stage 0.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Shift the pipeline by one stage; the truncating cast drops the oldest entry,
  // which also covers LATENCY=1 where stage 0 is the output stage.
  always_comb begin
    vld_d  = LATENCY'({vld_q, instr_req_i});
    err_d  = LATENCY'({err_q, stage0_err});
    data_d = PW'({data_q, stage0_data});
    cnt_d  = cnt_q + {2'b00, instr_req_i} - {2'b00, vld_q[LATENCY-1]};
  end

  // Pipeline and in-flight counter registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      vld_q  <= '0;
      err_q  <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      err_q  <= err_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  // Bubbles carry zero data and err, so the last stage can drive outputs directly.
  always_comb begin
    instr_rvalid_o = vld_q[LATENCY-1];
    instr_rdata_o  = data_q[LATENCY-1];
    instr_err_o    = err_q[LATENCY-1];
    pending_cnt_o  = cnt_q;
  end

endmodule

// File: tb/tb_miriscv_imem_responder.sv
// Bench for miriscv_imem_responder: three instances (LATENCY 1, 3, 4) share one
// stimulus stream; each is checked against a queue-based response model.
module tb_miriscv_imem_responder;

  localparam int unsigned MW        = 64;
  localparam logic [31:0] MEM_BYTES = 32'(MW * 4);

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] laddr = '0;
  logic [31:0] wdata = '0;

  logic [2:0]  rvalid;
  logic [2:0]  err;
  logic [31:0] rdata [3];
  logic [2:0]  cnt [3];

  always #5 clk = ~clk;

  miriscv_imem_responder #(.XLEN(32), .MEM_WORDS(MW), .LATENCY(1)) u_l1 (
    .clk_i(clk), .arstn_i(arstn), .instr_req_i(req), .instr_addr_i(addr),
    .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]), .instr_err_o(err[0]),
    .load_we_i(we), .load_addr_i(laddr), .load_wdata_i(wdata), .pending_cnt_o(cnt[0]));

  miriscv_imem_responder #(.XLEN(32), .MEM_WORDS(MW), .LATENCY(3)) u_l3 (
    .clk_i(clk), .arstn_i(arstn), .instr_req_i(req), .instr_addr_i(addr),
    .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]), .instr_err_o(err[1]),
    .load_we_i(we), .load_addr_i(laddr), .load_wdata_i(wdata), .pending_cnt_o(cnt[1]));

  miriscv_imem_responder #(.XLEN(32), .MEM_WORDS(MW), .LATENCY(4)) u_l4 (
    .clk_i(clk), .arstn_i(arstn), .instr_req_i(req), .instr_addr_i(addr),
    .instr_rvalid_o(rvalid[2]), .instr_rdata_o(rdata[2]), .instr_err_o(err[2]),
    .load_we_i(we), .load_addr_i(laddr), .load_wdata_i(wdata), .pending_cnt_o(cnt[2]));

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t        mq [3][$];
  logic [31:0] mem_m [MW];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compare every instance against its model queue for the current cycle.
  task automatic check_outputs();
    for (int i = 0; i < 3; i++) begin
      logic  exp_v;
      rsp_t  h;
      exp_v  = (mq[i].size() != 0) && (mq[i][0].due == cyc);
      h.data = '0;
      h.err  = 1'b0;
      h.due  = 0;
      if (exp_v) h = mq[i][0];
      chk($sformatf("rvalid_L%0d", lat_of(i)), 32'(rvalid[i]), 32'(exp_v));
      chk($sformatf("rdata_L%0d", lat_of(i)), rdata[i], h.data);
      chk($sformatf("err_L%0d", lat_of(i)), 32'(err[i]), 32'(h.err));
      chk($sformatf("pending_L%0d", lat_of(i)), {29'b0, cnt[i]}, 32'(mq[i].size()));
      if (exp_v) void'(mq[i].pop_front());
    end
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_rvalid_L%0d", tag, lat_of(i)), 32'(rvalid[i]), 32'd0);
      chk($sformatf("%s_rdata_L%0d", tag, lat_of(i)), rdata[i], 32'd0);
      chk($sformatf("%s_err_L%0d", tag, lat_of(i)), 32'(err[i]), 32'd0);
      chk($sformatf("%s_cnt_L%0d", tag, lat_of(i)), {29'b0, cnt[i]}, 32'd0);
    end
  endtask

  // One clock cycle of stimulus; the model reads before it writes.
  task automatic step(input logic r, input logic [31:0] a, input logic w,
                      input logic [31:0] la, input logic [31:0] wd);
    rsp_t e;
    logic bad;
    req = r; addr = a; we = w; laddr = la; wdata = wd;
    if (r) begin
      bad    = (a[1:0] != 2'b00) || (a >= MEM_BYTES);
      e.data = bad ? 32'd0 : mem_m[a[7:2]];
      e.err  = bad;
      for (int i = 0; i < 3; i++) begin
        e.due = cyc + lat_of(i);
        mq[i].push_back(e);
      end
    end
    if (w && (la[1:0] == 2'b00) && (la < MEM_BYTES)) mem_m[la[7:2]] = wd;
    @(posedge clk);
    #1;
    cyc++;
    req = 1'b0;
    we  = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic fetch(input logic [31:0] a);
    step(1'b1, a, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic load(input logic [31:0] la, input logic [31:0] wd);
    step(1'b0, 32'd0, 1'b1, la, wd);
  endtask

  // Reset mid-cycle with request and load driven; neither may take effect.
  task automatic do_reset(input int n);
    #2;
    arstn = 1'b0;
    req = 1'b1; addr = 32'h14; we = 1'b1; laddr = 32'h14; wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) mq[i].delete();
    #1;
    check_idle("rst_async");
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      check_idle("rst_hold");
    end
    #2;
    arstn = 1'b1;
    req = 1'b0;
    we  = 1'b0;
    #1;
    check_idle("rst_release");
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned m;
    m = $urandom_range(0, 11);
    case (m)
      7:       return 32'($urandom_range(0, MW - 1) * 4) | 32'($urandom_range(1, 3));
      8:       return MEM_BYTES + 32'($urandom_range(0, 15) * 4);
      9:       return $urandom | 32'h8000_0000;
      10:      return MEM_BYTES - 32'd4;
      11:      return 32'($urandom_range(0, MW - 1) * 4);
      default: return 32'($urandom_range(0, 15) * 4);
    endcase
  endfunction

  initial begin
    // Power-on reset
    @(posedge clk);
    #1;
    check_idle("por");
    @(posedge clk);
    #3;
    arstn = 1'b1;
    #1;
    check_idle("por_release");

    // Preload the whole array with random contents
    for (int w = 0; w < int'(MW); w++) load(32'(w * 4), $urandom);

    // Back-to-back fetches of two loaded words
    load(32'h0, 32'h0000_0093);
    load(32'h4, 32'h0010_0113);
    fetch(32'h0);
    fetch(32'h4);
    idle(5);

    // Fetch, gap, fetch
    fetch(32'h0);
    idle(1);
    fetch(32'h8);
    idle(6);

    // Misaligned and out-of-range fetches, then an aligned one and the top word
    fetch(32'h2);
    fetch(MEM_BYTES);
    fetch(32'h4);
    fetch(MEM_BYTES - 32'd4);
    idle(5);

    // Bad load addresses must be ignored
    load(32'h0000_0011, 32'h1111_1111);
    load(MEM_BYTES, 32'h2222_2222);
    fetch(32'h10);
    fetch(32'h0);
    idle(5);

    // Same-cycle load and fetch of one word, then fetch again
    load(32'h14, 32'hAAAA_AAAA);
    step(1'b1, 32'h14, 1'b1, 32'h14, 32'h5555_5555);
    fetch(32'h14);
    idle(5);

    // Reset with responses in flight; memory must survive
    fetch(32'h0);
    fetch(32'h4);
    do_reset(1);
    idle(6);
    fetch(32'h14);
    fetch(32'h0);
    fetch(32'h4);
    idle(5);

    // Request on the very first edge after reset release
    do_reset(2);
    fetch(32'h8);
    idle(5);

    // Continuous stream with incrementing addresses
    for (int k = 0; k < 64; k++) begin
      fetch(32'(k * 4));
      for (int i = 0; i < 3; i++)
        if (k + 1 >= lat_of(i))
          chk($sformatf("steady_cnt_L%0d", lat_of(i)), {29'b0, cnt[i]}, 32'(lat_of(i)));
    end
    idle(5);

    // Random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(int'($urandom_range(1, 2)));
      end else begin
        step(($urandom_range(0, 3) != 0), rand_addr(),
             ($urandom_range(0, 2) == 0), rand_addr(), $urandom);
      end
    end
    idle(6);

    for (int i = 0; i < 3; i++)
      chk($sformatf("drained_L%0d", lat_of(i)), 32'(mq[i].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
